npu_pool_packer: RTL and testbench

Downstream stage of the NPU argmax/pooling comparator. Collects the per-group 8-bit pooled results (one signed byte per comparison event), packs four consecutive bytes little-endian into 32-bit words, and presents them with word addresses on a valid/ready write port toward layer SRAM. An internal word FIFO decouples comparator bursts from memory stalls, and a flush command emits the final partial word with byte enables.

---
 rtl/npu_pack_pkg.sv | 34 +++
 rtl/pack_word_fifo.sv | 71 +++++++
 rtl/npu_pool_packer.sv | 173 +++++++++++++++++
 tb/tb_npu_pool_packer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : npu_pack_pkg
// Purpose  : Shared types, constants and helpers for the pooled-byte packer.
// Revision : 1.0 - initial release
// ============================================================================
package npu_pack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } pack_state_t;

    localparam int         LANES   = 4;
    localparam int         LANE_W  = $clog2(LANES);
    localparam logic [7:0] SAT_POS = 8'h7F;
    localparam logic [7:0] SAT_NEG = 8'h80;

    // Lane count 0 means all lanes were filled, i.e. a complete word.
    function automatic logic [LANES-1:0] byteen_from_lane(input logic [LANE_W-1:0] lane);
        logic [LANES-1:0] be;
        if (lane == '0) begin
            be = '1;
        end else begin
            be = LANES'((1 << lane) - 1);
        end
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pack_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pack_word_fifo
// Purpose  : Synchronous word FIFO of {addr, byteen, data}; head reads 0 when empty.
// Revision : 1.0 - initial release
// ============================================================================
module pack_word_fifo #(
    parameter int  DEPTH  = 4,
    parameter int  ADDR_W = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [3:0]        push_be,
    input  logic [31:0]       push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [3:0]        head_be,
    output logic [31:0]       head_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    localparam int ENT_W = ADDR_W + 36;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;
    logic [ENT_W-1:0] head;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {push_addr, push_be, push_data};
    end

    assign head      = empty ? '0 : mem[rd_ptr];
    assign head_addr = head[ENT_W-1 -: ADDR_W];
    assign head_be   = head[35:32];
    assign head_data = head[31:0];
    assign count     = cnt;

endmodule
`default_nettype wire

// File: rtl/npu_pool_packer.sv
`default_nettype none
// ============================================================================
// Module   : npu_pool_packer
// Purpose  : Packs pooled bytes into addressed 32-bit words for layer SRAM.
//            Optional saturation statistics: NPU_POOL_SAT_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module npu_pool_packer
    import npu_pack_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [3:0]        out_byteen,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] words_written,
    output logic [15:0]       sat_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    pack_state_t             state;
    pack_state_t             state_nxt;
    logic [LANE_W-1:0]       lane;
    logic [8*(LANES-1)-1:0]  partial;
    logic [ADDR_W-1:0]       addr_ptr;
    logic                    overflow_q;
    logic [ADDR_W-1:0]       words_q;

    logic                    accept;
    logic                    push;
    logic [3:0]              push_be;
    logic [31:0]             push_data;
    logic                    pop;
    logic                    load;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [CNT_W-1:0]        fifo_count;

    assign load = start & ((state == ST_IDLE) | (state == ST_DONE));
    assign pop  = ~fifo_empty & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        push      = 1'b0;
        push_be   = '0;
        push_data = '0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                accept = in_valid;
                if (in_valid && lane == LANE_W'(LANES - 1)) begin
                    push      = 1'b1;
                    push_be   = '1;
                    push_data = {in_data, partial};
                end
                if (flush) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Unfilled lanes are already zero: the buffer clears on every push.
                if (lane != '0) begin
                    push      = 1'b1;
                    push_be   = byteen_from_lane(lane);
                    push_data = {8'h00, partial};
                end
                state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty || (fifo_count == CNT_W'(1) && pop)) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane       <= '0;
            partial    <= '0;
            addr_ptr   <= '0;
            overflow_q <= 1'b0;
            words_q    <= '0;
        end else if (load) begin
            lane       <= '0;
            partial    <= '0;
            addr_ptr   <= base_addr;
            overflow_q <= 1'b0;
            words_q    <= '0;
        end else begin
            if (pop) words_q <= words_q + 1'b1;
            // A dropped word still consumes its address slot.
            if (push && fifo_full && !pop) overflow_q <= 1'b1;
            if (push) begin
                addr_ptr <= addr_ptr + 1'b1;
                lane     <= '0;
                partial  <= '0;
            end else if (accept) begin
                case (lane)
                    2'd0:    partial[7:0]   <= in_data;
                    2'd1:    partial[15:8]  <= in_data;
                    default: partial[23:16] <= in_data;
                endcase
                lane <= lane + 1'b1;
            end
        end
    end

    pack_word_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_addr (addr_ptr),
        .push_be   (push_be),
        .push_data (push_data),
        .pop       (pop),
        .head_addr (out_addr),
        .head_be   (out_byteen),
        .head_data (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign out_valid     = ~fifo_empty;
    assign busy          = (state == ST_RUN) | (state == ST_FLUSH) | (state == ST_DRAIN);
    assign done          = (state == ST_DONE);
    assign overflow      = overflow_q;
    assign words_written = words_q;

`ifdef NPU_POOL_SAT_STATS_EN
    logic [15:0] sat_q;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            sat_q <= '0;
        end else if (accept && (in_data == SAT_POS || in_data == SAT_NEG) && sat_q != 16'hFFFF) begin
            sat_q <= sat_q + 1'b1;
        end
    end

    assign sat_count = sat_q;
`else
    assign sat_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_npu_pool_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_npu_pool_packer
// Purpose  : Self-checking bench for npu_pool_packer (vectors, directed, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_npu_pool_packer;

    localparam int DEPTH = 4;
    localparam int P_IDLE = 0, P_RUN = 1, P_FLUSH = 2, P_DRAIN = 3, P_DONE = 4;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, flush, out_ready;
    logic [15:0] base_addr;
    logic [7:0]  in_data;
    logic        out_valid, busy, done, overflow;
    logic [31:0] out_data;
    logic [15:0] out_addr, words_written, sat_count;
    logic [3:0]  out_byteen;

    npu_pool_packer #(.ADDR_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_byteen(out_byteen), .busy(busy), .done(done),
        .overflow(overflow), .words_written(words_written), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } word_t;

    typedef struct {
        logic [15:0] base;
        int          nbytes;
        logic [63:0] bytes;
        int          nwords;
        word_t       w0;
        word_t       w1;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: what the word queue and status should be, from the layer rules.
    word_t      m_q[$];
    logic [7:0] m_bytes[$];
    int         m_phase = P_IDLE;
    logic [15:0] m_ptr = '0, m_words = '0, m_sat = '0;
    logic        m_ovf = 1'b0;
    word_t       got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic word_t make_word();
        word_t w;
        w.addr = m_ptr;
        w.be   = 4'((1 << m_bytes.size()) - 1);
        w.data = '0;
        foreach (m_bytes[i]) w.data |= 32'(m_bytes[i]) << (8 * i);
        return w;
    endfunction

    task automatic model_step(input bit pop);
        int    pre = m_q.size();
        bit    has_push = 0;
        bit    in_drain = 0;
        word_t w = '0;
        if (reset) begin
            m_q.delete(); m_bytes.delete();
            m_phase = P_IDLE; m_ptr = '0; m_words = '0; m_sat = '0; m_ovf = 1'b0;
            return;
        end
        case (m_phase)
            P_IDLE, P_DONE: if (start) begin
                m_phase = P_RUN; m_ptr = base_addr; m_bytes.delete();
                m_words = '0; m_ovf = 1'b0; m_sat = '0;
            end
            P_RUN: begin
                if (in_valid) begin
                    m_bytes.push_back(in_data);
                    if ((in_data == 8'h7F || in_data == 8'h80) && m_sat != 16'hFFFF) m_sat++;
                    if (m_bytes.size() == 4) begin has_push = 1; w = make_word(); end
                end
                if (flush) m_phase = P_FLUSH;
            end
            P_FLUSH: begin
                if (m_bytes.size() > 0) begin has_push = 1; w = make_word(); end
                m_phase = P_DRAIN;
            end
            default: in_drain = 1;
        endcase
        if (pop) begin void'(m_q.pop_front()); m_words++; end
        if (has_push) begin
            if (pre == DEPTH && !pop) m_ovf = 1'b1;
            else m_q.push_back(w);
            m_ptr++;
            m_bytes.delete();
        end
        if (in_drain && m_q.size() == 0) m_phase = P_DONE;
    endtask

    task automatic check_outputs();
        word_t head = (m_q.size() > 0) ? m_q[0] : '0;
        logic [15:0] exp_sat;
`ifdef NPU_POOL_SAT_STATS_EN
        exp_sat = m_sat;
`else
        exp_sat = 16'h0000;
`endif
        chk("out_valid", out_valid, m_q.size() > 0);
        chk("out_data", out_data, head.data);
        chk("out_addr", out_addr, head.addr);
        chk("out_byteen", out_byteen, head.be);
        chk("busy", busy, m_phase == P_RUN || m_phase == P_FLUSH || m_phase == P_DRAIN);
        chk("done", done, m_phase == P_DONE);
        chk("overflow", overflow, m_ovf);
        chk("words_written", words_written, m_words);
        chk("sat_count", sat_count, exp_sat);
    endtask

    task automatic tick();
        bit pop = out_ready && out_valid;
        if (pop) got.push_back({out_addr, out_byteen, out_data});
        model_step(out_ready && m_q.size() > 0);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic begin_layer(input logic [15:0] base, input logic rdy);
        got.delete();
        out_ready = rdy; base_addr = base; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1; in_data = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit noisy);
        int n = 0;
        while (!done && n < budget) begin
            if (noisy) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = 8'($urandom);
                flush     = 1'($urandom_range(0, 1));
            end
            tick();
            n++;
        end
        in_valid = 1'b0; flush = 1'b0;
        chk("done_reached", done, 1'b1);
    endtask

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0100, 4, 64'h04030201, 1, '{16'h0100, 4'hF, 32'h04030201}, '0};
        vecs[1] = '{16'h0100, 6, 64'h665544332211, 2,
                    '{16'h0100, 4'hF, 32'h44332211}, '{16'h0101, 4'h3, 32'h00006655}};
        vecs[2] = '{16'hFFFF, 8, 64'hA7A6A5A4A3A2A1A0, 2,
                    '{16'hFFFF, 4'hF, 32'hA3A2A1A0}, '{16'h0000, 4'hF, 32'hA7A6A5A4}};
        vecs[3] = '{16'h0200, 1, 64'h7F, 1, '{16'h0200, 4'h1, 32'h0000007F}, '0};
        vecs[4] = '{16'h0300, 7, 64'h07060504030201, 2,
                    '{16'h0300, 4'hF, 32'h04030201}, '{16'h0301, 4'h7, 32'h00070605}};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; flush = 1'b0;
        out_ready = 1'b0; base_addr = '0; in_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Table-driven layers, always drained with ready high.
        for (int v = 0; v < 5; v++) begin
            begin_layer(vecs[v].base, 1'b1);
            for (int i = 0; i < vecs[v].nbytes; i++) send_byte(vecs[v].bytes[8*i +: 8]);
            flush = 1'b1; tick(); flush = 1'b0;
            wait_done(50, 1'b0);
            chk("vec_nwords", got.size(), vecs[v].nwords);
            chk("vec_words_written", words_written, vecs[v].nwords);
            for (int k = 0; k < vecs[v].nwords && k < got.size(); k++)
                chk("vec_word", got[k], (k == 0) ? vecs[v].w0 : vecs[v].w1);
        end

        // FIFO overflow: 5 words with no drain, fifth dropped.
        begin_layer(16'h0400, 1'b0);
        for (int i = 0; i < 20; i++) send_byte(8'(i + 1));
        chk("ovf_flag", overflow, 1'b1);
        out_ready = 1'b1;
        flush = 1'b1; tick(); flush = 1'b0;
        wait_done(50, 1'b0);
        chk("ovf_nwords", got.size(), 4);
        chk("ovf_words_written", words_written, 16'd4);
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            chk("ovf_addr", got[k].addr, 16'h0400 + 16'(k));
            chk("ovf_data", got[k].data,
                {8'(4*k + 4), 8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1)});
        end

        // Byte accepted in the same cycle as flush.
        begin_layer(16'h0500, 1'b1);
        send_byte(8'h7F);
        send_byte(8'h80);
        in_valid = 1'b1; in_data = 8'h00; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        wait_done(50, 1'b0);
        chk("sameflush_nwords", got.size(), 1);
        if (got.size() > 0) chk("sameflush_word", got[0], {16'h0500, 4'h7, 32'h0000807F});
`ifdef NPU_POOL_SAT_STATS_EN
        chk("sameflush_sat", sat_count, 16'd2);
`else
        chk("sameflush_sat", sat_count, 16'd0);
`endif

        // Reset while draining with words queued.
        begin_layer(16'h0600, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h30 + i));
        flush = 1'b1; tick(); flush = 1'b0;
        tick();
        tick();
        chk("drain_busy", busy, 1'b1);
        chk("drain_valid", out_valid, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_words", words_written, 16'd0);
        chk("rst_data", out_data, 32'd0);
        tick();

        // Randomised layers against the reference model.
        for (int l = 0; l < 8; l++) begin
            begin_layer(16'($urandom), 1'($urandom_range(0, 1)));
            for (int c = 0; c < 40; c++) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                in_data   = ($urandom_range(0, 3) == 0) ?
                            (($urandom_range(0, 1) == 1) ? 8'h7F : 8'h80) : 8'($urandom);
                out_ready = ($urandom_range(0, 9) < 6);
                start     = ($urandom_range(0, 15) == 0);
                tick();
            end
            start = 1'b0; in_valid = 1'b0;
            flush = 1'b1; tick(); flush = 1'b0;
            wait_done(300, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
